// File: rtl/pkt_serializer.sv
// Packet serializer: buffers parallel packets in a small FIFO and shifts each one
// out MSB-first on ser_data/ser_valid, with a guaranteed idle gap between packets.
//
// state    | meaning
// ST_IDLE  | outputs low; pops the FIFO head when en and a packet is queued
// ST_SHIFT | drives one packet bit per cycle, MSB first
// ST_GAP   | outputs low for GAP cycles before returning to idle
module pkt_serializer #(
   parameter int PKT_W = 64,
   parameter int DEPTH = 4,
   parameter int GAP   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [PKT_W-1:0]       s_data,
   input  logic                   s_valid,
   output logic                   s_ready,
   output logic                   ser_data,
   output logic                   ser_valid,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic [15:0]            pkt_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int BW = $clog2(PKT_W);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

   logic [PKT_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;
   state_t           state;
   logic [PKT_W-1:0] shreg;
   logic [BW-1:0]    bit_cnt;
   logic [7:0]       gap_cnt;

   // s_ready looks only at registered occupancy, so a pop never frees a slot same-cycle
   assign s_ready = (fifo_level != LW'(DEPTH));
   assign push    = s_valid && s_ready;
   assign pop     = (state == ST_IDLE) && en && (fifo_level != '0);
   assign busy    = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= s_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      fifo_level <= fifo_level + 1'b1;
         else if (pop && !push) fifo_level <= fifo_level - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         ser_data  <= 1'b0;
         ser_valid <= 1'b0;
         pkt_count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               ser_valid <= 1'b0;
               ser_data  <= 1'b0;
               if (pop) begin
                  shreg   <= mem[rd_ptr];
                  bit_cnt <= '0;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               ser_valid <= 1'b1;
               ser_data  <= shreg[PKT_W-1];
               shreg     <= {shreg[PKT_W-2:0], 1'b0};
               bit_cnt   <= bit_cnt + 1'b1;
               if (bit_cnt == BW'(PKT_W-1)) begin
                  pkt_count <= pkt_count + 1'b1;
                  if (GAP > 0) begin
                     gap_cnt <= 8'(GAP-1);
                     state   <= ST_GAP;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            ST_GAP: begin
               ser_valid <= 1'b0;
               ser_data  <= 1'b0;
               if (gap_cnt == '0) state <= ST_IDLE;
               else               gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
